xreg_wb_arbiter: RTL and testbench

XREG_WB_ARBITER -- requirements
Module: xreg_wb_arbiter

---
 rtl/xreg_wb_arbiter_pkg.sv | 16 +
 rtl/xreg_wb_arbiter_rr_arbiter.sv | 39 +++
 rtl/xreg_wb_arbiter.sv | 123 ++++++++++++
 tb/tb_xreg_wb_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/xreg_wb_arbiter_pkg.sv
// Shared core constants for the register writeback path.
package xreg_wb_arbiter_pkg;

    // Default register data width of the core.
    localparam int CORE_XLEN = 32;

    // Architectural register index width and register count.
    localparam int REG_IDX_W = 4;
    localparam int REG_COUNT = 16;

    // Width of a requester index for a given requester count (at least 1 bit).
    function automatic int req_idx_w(input int nreq);
        return (nreq > 2) ? $clog2(nreq) : 1;
    endfunction

endpackage

// File: rtl/xreg_wb_arbiter_rr_arbiter.sv
// Round-robin selector: picks the first asserted request at or after the
// search start pointer, wrapping modulo NREQ. Purely combinational.
module rr_arbiter
    import xreg_wb_arbiter_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int PW   = req_idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   gnt_idx
);

    localparam int SW = PW + 1;

    logic [SW-1:0] cand;
    logic          found;

    // Scan requesters in rotated order and take the first valid one.
    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr} + SW'(k);
            if (cand >= SW'(NREQ)) begin
                cand = cand - SW'(NREQ);
            end
            if (!found && req[cand[PW-1:0]]) begin
                grant[cand[PW-1:0]] = 1'b1;
                gnt_idx             = cand[PW-1:0];
                found               = 1'b1;
            end
        end
    end

endmodule

// File: rtl/xreg_wb_arbiter.sv
// Writeback arbiter with register scoreboard.
// NREQ requesters compete round-robin for a single registered register-file
// write port. The scoreboard tracks registers reserved by issue and cleared
// by their writeback.
//
// Handshake: a writeback on requester i is accepted in the cycle where
// req_valid[i] and req_ready[i] are both high; req_ready is a one-hot grant
// that depends only on req_valid and the round-robin pointer, never on
// req_index/req_data. A requester may hold valid across cycles without
// being accepted and must keep index/data stable until accepted.
module xreg_wb_arbiter
    import xreg_wb_arbiter_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int XLEN = CORE_XLEN
) (
    input  logic                                clk,
    input  logic                                rstn,
    input  logic [NREQ-1:0]                     req_valid,
    input  logic [NREQ-1:0][REG_IDX_W-1:0]      req_index,
    input  logic [NREQ-1:0][XLEN-1:0]           req_data,
    output logic [NREQ-1:0]                     req_ready,
    input  logic                                alloc_valid,
    input  logic [REG_IDX_W-1:0]                alloc_index,
    output logic [REG_COUNT-1:0]                pending,
    output logic                                wreq,
    output logic [REG_IDX_W-1:0]                windex,
    output logic [XLEN-1:0]                     wdata,
    output logic [req_idx_w(NREQ)-1:0]          dbg_rr_ptr
);

    localparam int PW = req_idx_w(NREQ);

    logic [PW-1:0]        rr_ptr;      // last granted requester
    logic                 rr_seen;     // a grant has happened since reset
    logic [PW-1:0]        start_ptr;
    logic [NREQ-1:0]      grant;
    logic [PW-1:0]        gnt_idx;
    logic                 hs;
    logic [REG_IDX_W-1:0] sel_index;
    logic [XLEN-1:0]      sel_data;
    logic [REG_COUNT-1:0] pending_nxt;

    // Search begins one past the last grant; before any grant it begins at 0
    // so a fresh core grants requester 0 first.
    always_comb begin
        start_ptr = '0;
        if (rr_seen && (rr_ptr != PW'(NREQ - 1))) begin
            start_ptr = rr_ptr + PW'(1);
        end
    end

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr (
        .req     (req_valid),
        .ptr     (start_ptr),
        .grant   (grant),
        .gnt_idx (gnt_idx)
    );

    // Grant is suppressed while reset is held; the selected requester's
    // payload is muxed out for the output registers and scoreboard.
    always_comb begin
        req_ready = rstn ? grant : '0;
        hs        = |req_ready;
        sel_index = req_index[gnt_idx];
        sel_data  = req_data[gnt_idx];
    end

    // Round-robin pointer moves to the granted requester on acceptance only.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_ptr  <= '0;
            rr_seen <= 1'b0;
        end else if (hs) begin
            rr_ptr  <= gnt_idx;
            rr_seen <= 1'b1;
        end
    end

    // Register-file write port: one-cycle strobe per accepted writeback to a
    // non-zero register; index/data hold when no write is issued.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wreq   <= 1'b0;
            windex <= '0;
            wdata  <= '0;
        end else begin
            wreq <= hs && (sel_index != '0);
            if (hs && (sel_index != '0)) begin
                windex <= sel_index;
                wdata  <= sel_data;
            end
        end
    end

    // Scoreboard update: writeback clears, then alloc sets so that a
    // same-cycle alloc of the same register wins. Register 0 never pends.
    always_comb begin
        pending_nxt = pending;
        if (hs) begin
            pending_nxt[sel_index] = 1'b0;
        end
        if (alloc_valid) begin
            pending_nxt[alloc_index] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    // Scoreboard state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    assign dbg_rr_ptr = rr_ptr;

endmodule

// File: tb/tb_xreg_wb_arbiter.sv
// Directed bench for xreg_wb_arbiter: a vector table covering rotation,
// scoreboard, collision, stale writeback and x0 drop, plus hand-written
// reset sequences.
module tb_xreg_wb_arbiter;

    localparam int NREQ = 3;
    localparam int XLEN = 32;

    logic                       clk;
    logic                       rstn;
    logic [NREQ-1:0]            req_valid;
    logic [NREQ-1:0][3:0]       req_index;
    logic [NREQ-1:0][XLEN-1:0]  req_data;
    logic [NREQ-1:0]            req_ready;
    logic                       alloc_valid;
    logic [3:0]                 alloc_index;
    logic [15:0]                pending;
    logic                       wreq;
    logic [3:0]                 windex;
    logic [XLEN-1:0]            wdata;
    logic [1:0]                 dbg_rr_ptr;

    int n_tests = 0;
    int n_fail  = 0;

    xreg_wb_arbiter #(
        .NREQ (NREQ),
        .XLEN (XLEN)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .req_valid   (req_valid),
        .req_index   (req_index),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .alloc_valid (alloc_valid),
        .alloc_index (alloc_index),
        .pending     (pending),
        .wreq        (wreq),
        .windex      (windex),
        .wdata       (wdata),
        .dbg_rr_ptr  (dbg_rr_ptr)
    );

    // Clock: posedges at 5, 15, 25 ...; inputs change on negedges.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  valid;
        logic [3:0]  i0;
        logic [3:0]  i1;
        logic [3:0]  i2;
        logic        av;
        logic [3:0]  ai;
        logic [2:0]  e_ready;
        logic        e_wreq;
        logic [3:0]  e_windex;
        logic [15:0] e_pending;
        logic [1:0]  e_ptr;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] data_of(input int r, input int n);
        return 32'hD000_0000 | (32'(r) << 16) | 32'(n);
    endfunction

    function automatic vec_t mk(input logic [2:0] valid, input logic [3:0] i0, input logic [3:0] i1,
                                input logic [3:0] i2, input logic av, input logic [3:0] ai,
                                input logic [2:0] e_ready, input logic e_wreq, input logic [3:0] e_windex,
                                input logic [15:0] e_pending, input logic [1:0] e_ptr);
        vec_t v;
        v.valid = valid; v.i0 = i0; v.i1 = i1; v.i2 = i2; v.av = av; v.ai = ai;
        v.e_ready = e_ready; v.e_wreq = e_wreq; v.e_windex = e_windex;
        v.e_pending = e_pending; v.e_ptr = e_ptr;
        return v;
    endfunction

    task automatic idle_inputs();
        req_valid   = '0;
        req_index   = '0;
        req_data    = '0;
        alloc_valid = 1'b0;
        alloc_index = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        logic [31:0] exp_wd;
        int          gr;

        rstn = 1'b1;
        idle_inputs();

        // Rotation (0,1,2,0,1,2), then scoreboard alloc/writeback of r5.
        vecs[0]  = mk(3'b111, 4'd1, 4'd2, 4'd3, 1'b0, 4'd0, 3'b001, 1'b1, 4'd1, 16'h0000, 2'd0);
        vecs[1]  = mk(3'b111, 4'd1, 4'd2, 4'd3, 1'b0, 4'd0, 3'b010, 1'b1, 4'd2, 16'h0000, 2'd1);
        vecs[2]  = mk(3'b111, 4'd1, 4'd2, 4'd3, 1'b0, 4'd0, 3'b100, 1'b1, 4'd3, 16'h0000, 2'd2);
        vecs[3]  = mk(3'b111, 4'd1, 4'd2, 4'd3, 1'b0, 4'd0, 3'b001, 1'b1, 4'd1, 16'h0000, 2'd0);
        vecs[4]  = mk(3'b111, 4'd1, 4'd2, 4'd3, 1'b0, 4'd0, 3'b010, 1'b1, 4'd2, 16'h0000, 2'd1);
        vecs[5]  = mk(3'b111, 4'd1, 4'd2, 4'd3, 1'b0, 4'd0, 3'b100, 1'b1, 4'd3, 16'h0000, 2'd2);
        vecs[6]  = mk(3'b000, 4'd0, 4'd0, 4'd0, 1'b1, 4'd5, 3'b000, 1'b0, 4'd3, 16'h0020, 2'd2);
        vecs[7]  = mk(3'b000, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0, 3'b000, 1'b0, 4'd3, 16'h0020, 2'd2);
        vecs[8]  = mk(3'b000, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0, 3'b000, 1'b0, 4'd3, 16'h0020, 2'd2);
        vecs[9]  = mk(3'b001, 4'd5, 4'd0, 4'd0, 1'b0, 4'd0, 3'b001, 1'b1, 4'd5, 16'h0000, 2'd0);
        // Collision: alloc r7 and writeback r7 together -> bit stays set.
        vecs[10] = mk(3'b100, 4'd0, 4'd0, 4'd7, 1'b1, 4'd7, 3'b100, 1'b1, 4'd7, 16'h0080, 2'd2);
        // Writeback to a register not pending: performed, pending unchanged.
        vecs[11] = mk(3'b010, 4'd0, 4'd9, 4'd0, 1'b0, 4'd0, 3'b010, 1'b1, 4'd9, 16'h0080, 2'd1);
        // Alloc of r0 is ignored.
        vecs[12] = mk(3'b000, 4'd0, 4'd0, 4'd0, 1'b1, 4'd0, 3'b000, 1'b0, 4'd9, 16'h0080, 2'd1);
        // Pointer 1: search 2 (idle), wraps to 0.
        vecs[13] = mk(3'b011, 4'd7, 4'd4, 4'd0, 1'b0, 4'd0, 3'b001, 1'b1, 4'd7, 16'h0000, 2'd0);
        vecs[14] = mk(3'b110, 4'd0, 4'd10, 4'd11, 1'b1, 4'd11, 3'b010, 1'b1, 4'd10, 16'h0800, 2'd1);
        // x0 drop: requester 1 alone with index 0.
        vecs[15] = mk(3'b010, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0, 3'b010, 1'b0, 4'd10, 16'h0800, 2'd1);

        // Reset state, with valid held high to show ready is gated.
        @(negedge clk);
        rstn      = 1'b0;
        req_valid = 3'b111;
        req_index = {4'd3, 4'd2, 4'd1};
        #2;
        check("reset_ready", req_ready, 3'b000);
        check("reset_wreq", wreq, 1'b0);
        check("reset_windex", windex, 4'd0);
        check("reset_wdata", wdata, 32'd0);
        check("reset_pending", pending, 16'h0000);
        check("reset_ptr", dbg_rr_ptr, 2'd0);
        @(negedge clk);
        idle_inputs();
        rstn = 1'b1;

        // Idle after reset: nothing happens for 10 cycles.
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            check("idle_wreq", wreq, 1'b0);
            check("idle_pending", pending, 16'h0000);
        end

        // Table-driven sequence from a fresh reset.
        do_reset();
        exp_wd = '0;
        for (int n = 0; n < 16; n++) begin
            @(negedge clk);
            req_valid   = vecs[n].valid;
            req_index   = {vecs[n].i2, vecs[n].i1, vecs[n].i0};
            for (int r = 0; r < NREQ; r++) req_data[r] = data_of(r, n);
            alloc_valid = vecs[n].av;
            alloc_index = vecs[n].ai;
            #2;
            check($sformatf("v%0d_ready", n), req_ready, vecs[n].e_ready);
            @(posedge clk);
            #1;
            if (vecs[n].e_wreq) begin
                gr = 0;
                for (int r = 0; r < NREQ; r++) if (vecs[n].e_ready[r]) gr = r;
                exp_wd = data_of(gr, n);
            end
            check($sformatf("v%0d_wreq", n), wreq, vecs[n].e_wreq);
            check($sformatf("v%0d_windex", n), windex, vecs[n].e_windex);
            check($sformatf("v%0d_wdata", n), wdata, exp_wd);
            check($sformatf("v%0d_pending", n), pending, vecs[n].e_pending);
            check($sformatf("v%0d_ptr", n), dbg_rr_ptr, vecs[n].e_ptr);
        end

        // One-cycle strobe: after the x0 drop, idle keeps wreq low.
        @(negedge clk);
        idle_inputs();
        @(posedge clk);
        #1;
        check("post_drop_wreq", wreq, 1'b0);
        check("post_drop_ptr", dbg_rr_ptr, 2'd1);

        // Reset between a handshake and its write: the write is discarded.
        do_reset();
        @(negedge clk);
        alloc_valid = 1'b1;
        alloc_index = 4'd3;
        @(posedge clk);
        #1;
        check("mid_alloc_pending", pending, 16'h0008);
        @(negedge clk);
        alloc_valid = 1'b0;
        req_valid   = 3'b001;
        req_index   = {4'd0, 4'd0, 4'd3};
        req_data[0] = 32'hCAFE_0003;
        #2;
        check("mid_ready", req_ready, 3'b001);
        #1;
        rstn = 1'b0;
        #1;
        check("mid_ready_in_reset", req_ready, 3'b000);
        check("mid_pending_in_reset", pending, 16'h0000);
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            check("mid_wreq_in_reset", wreq, 1'b0);
        end
        @(negedge clk);
        idle_inputs();
        rstn = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            check("mid_wreq_after", wreq, 1'b0);
            check("mid_pending_after", pending, 16'h0000);
            check("mid_wdata_after", wdata, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
